regfile_scoreboard: RTL and testbench

//  Parametrised integer register file for the pipelined core: NRD read ports, two write-back

---
 rtl/regfile_scoreboard.sv | 116 +++++++++++
 tb/tb_regfile_scoreboard.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports, two write-back ports and a busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned  XLEN = 64,
    parameter int unsigned  NREG = 32,
    parameter int unsigned  NRD  = 2,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb0_we,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_we,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [XLEN-1:0]     wb1_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    output logic [AW:0]         pend_cnt,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   pend_cnt_q, pend_cnt_d;

    logic            wb0_act, wb1_act;
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] iss_vec;
    logic            iss_set;
    logic            cnt_inc, cnt_dec0, cnt_dec1;

    assign wb0_act = wb0_we && (wb0_addr != '0);
    assign wb1_act = wb1_we && (wb1_addr != '0);

    always_comb begin
        wb_clr = '0;
        if (wb0_act) wb_clr[wb0_addr] = 1'b1;
        if (wb1_act) wb_clr[wb1_addr] = 1'b1;
    end

    // A write-back retiring the current producer frees the destination in the same cycle.
    assign iss_ready = (iss_addr == '0) || !busy_q[iss_addr] || wb_clr[iss_addr];
    assign iss_set   = iss_valid && iss_ready && (iss_addr != '0);

    always_comb begin
        iss_vec = '0;
        if (iss_set) iss_vec[iss_addr] = 1'b1;
    end

    // Set wins over clear when issue and write-back hit the same register.
    assign busy_d = (busy_q & ~wb_clr) | iss_vec;

    assign cnt_inc  = iss_set && !busy_q[iss_addr];
    assign cnt_dec0 = wb0_act && busy_q[wb0_addr] && !iss_vec[wb0_addr];
    assign cnt_dec1 = wb1_act && busy_q[wb1_addr] && !iss_vec[wb1_addr]
                      && !(wb0_act && (wb0_addr == wb1_addr));

    assign pend_cnt_d = pend_cnt_q + CW'(cnt_inc) - CW'(cnt_dec0) - CW'(cnt_dec1);

    // Port 1 is applied first so port 0 overrides it on an address collision.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb1_act) regs_d[wb1_addr] = wb1_data;
        if (wb0_act) regs_d[wb0_addr] = wb0_data;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            rd_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : regs_q[addr];
            rd_busy[k]              = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wb0_act && (wb0_addr == addr)) begin
                rd_data[k*XLEN +: XLEN] = wb0_data;
            end else if (wb1_act && (wb1_addr == addr)) begin
                rd_data[k*XLEN +: XLEN] = wb1_data;
            end
            if (wb_clr[addr]) rd_busy[k] = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised bench for regfile_scoreboard against an array-based register/busy model.
// Honours REGFILE_BYPASS_EN when the same define is given to the bench.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = $clog2(NREG);

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wb0_we, wb1_we;
    logic [AW-1:0]       wb0_addr, wb1_addr;
    logic [XLEN-1:0]     wb0_data, wb1_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic [AW:0]         pend_cnt;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb0_we(wb0_we), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_we(wb1_we), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .pend_cnt(pend_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_written(input int a);
        return (a != 0) && ((wb0_we && int'(wb0_addr) == a) || (wb1_we && int'(wb1_addr) == a));
    endfunction

    function automatic logic [XLEN-1:0] m_rd_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb0_we && int'(wb0_addr) == a) return wb0_data;
        if (wb1_we && int'(wb1_addr) == a) return wb1_data;
`endif
        return m_regs[a];
    endfunction

    function automatic bit m_rd_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (m_written(a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic bit m_ready();
        int a = int'(iss_addr);
        return (a == 0) || !m_busy[a] || m_written(a);
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge under the current inputs.
    task automatic m_step();
        bit rdy = m_ready();
        bit clr [NREG];
        for (int i = 0; i < NREG; i++) clr[i] = m_written(i);
        if (wb1_we && wb1_addr != 0) m_regs[wb1_addr] = wb1_data;
        if (wb0_we && wb0_addr != 0) m_regs[wb0_addr] = wb0_data;
        for (int i = 0; i < NREG; i++) if (clr[i]) m_busy[i] = 1'b0;
        if (iss_valid && rdy && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    endtask

    task automatic check_all();
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rd_addr[k*AW +: AW]);
            check($sformatf("rd_data[%0d] x%0d", k, a), 64'(rd_data[k*XLEN +: XLEN]),
                  64'(m_rd_data(a)));
            check($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rd_busy[k]), 64'(m_rd_busy(a)));
        end
        check("iss_ready", 64'(iss_ready), 64'(m_ready()));
        check("pend_cnt", 64'(pend_cnt), 64'(m_pending()));
        check($sformatf("dbg_data x%0d", dbg_addr), 64'(dbg_data),
              (dbg_addr == 0) ? 64'd0 : 64'(m_regs[dbg_addr]));
    endtask

    // Inputs are set at the negedge; check, advance the model, move to the next negedge.
    task automatic cycle();
        #1;
        check_all();
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rd_addr = '0;  dbg_addr = '0;
        wb0_we = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_we = 1'b0; wb1_addr = '0; wb1_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1))
                                           : int'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset iss_ready", 64'(iss_ready), 64'd1);
        check("reset pend_cnt", 64'(pend_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Every address reads zero and idle after reset.
        for (int a = 0; a < NREG; a++) begin
            for (int k = 0; k < NRD; k++) set_rd(k, a);
            dbg_addr = AW'(a);
            cycle();
        end

        // Colliding write-backs: port 0 data wins; x0 stays zero.
        idle();
        wb0_we = 1; wb0_addr = 5; wb0_data = 64'hDEAD_BEEF;
        wb1_we = 1; wb1_addr = 5; wb1_data = 64'h1234;
        cycle();
        idle();
        wb0_we = 1; wb0_addr = 0; wb0_data = 64'd7;
        set_rd(0, 5);
        set_rd(1, 0);
        #1;
        check("collide x5", 64'(rd_data[0 +: XLEN]), 64'hDEAD_BEEF);
        cycle();
        idle();
        set_rd(1, 0);
        #1;
        check("x0 write dropped", 64'(rd_data[XLEN +: XLEN]), 64'd0);
        cycle();

        // Issue, rejected re-issue, then write-back release.
        idle();
        iss_valid = 1; iss_addr = 3;
        #1;
        check("issue x3 ready", 64'(iss_ready), 64'd1);
        cycle();
        idle();
        set_rd(0, 3);
        iss_valid = 1; iss_addr = 3;
        #1;
        check("x3 busy", 64'(rd_busy[0]), 64'd1);
        check("pend after x3", 64'(pend_cnt), 64'd1);
        check("reissue x3 stall", 64'(iss_ready), 64'd0);
        cycle();
        idle();
        wb1_we = 1; wb1_addr = 3; wb1_data = 64'd9;
        cycle();
        idle();
        set_rd(0, 3);
        #1;
        check("x3 released", 64'(rd_busy[0]), 64'd0);
        check("pend released", 64'(pend_cnt), 64'd0);
        check("x3 data", 64'(rd_data[0 +: XLEN]), 64'd9);
        cycle();

        // Issue and write-back to the same busy register: set wins, data stored.
        idle();
        iss_valid = 1; iss_addr = 7;
        cycle();
        idle();
        iss_valid = 1; iss_addr = 7;
        wb0_we = 1; wb0_addr = 7; wb0_data = 64'h55;
        #1;
        check("x7 reissue ready", 64'(iss_ready), 64'd1);
        cycle();
        idle();
        set_rd(1, 7);
        #1;
        check("x7 still busy", 64'(rd_busy[1]), 64'd1);
        check("x7 pend kept", 64'(pend_cnt), 64'd1);
        check("x7 data", 64'(rd_data[XLEN +: XLEN]), 64'h55);
        wb0_we = 1; wb0_addr = 7; wb0_data = 64'h55;
        cycle();

        // Same-cycle write versus read of x9.
        idle();
        wb0_we = 1; wb0_addr = 9; wb0_data = 64'h1111;
        cycle();
        idle();
        wb0_we = 1; wb0_addr = 9; wb0_data = 64'hABCD;
        set_rd(0, 9);
        dbg_addr = 9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass x9", 64'(rd_data[0 +: XLEN]), 64'hABCD);
`else
        check("no bypass x9", 64'(rd_data[0 +: XLEN]), 64'h1111);
`endif
        check("dbg x9 unbypassed", 64'(dbg_data), 64'h1111);
        check("x9 not busy", 64'(rd_busy[0]), 64'd0);
        cycle();
        idle();
        set_rd(0, 9);
        #1;
        check("x9 next cycle", 64'(rd_data[0 +: XLEN]), 64'hABCD);
        cycle();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NRD; k++) set_rd(k, rand_addr());
            dbg_addr  = AW'(rand_addr());
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_addr  = AW'(rand_addr());
            wb0_we    = ($urandom_range(0, 4) < 2);
            wb0_addr  = AW'(rand_addr());
            wb0_data  = {$urandom, $urandom};
            wb1_we    = ($urandom_range(0, 4) < 2);
            wb1_addr  = AW'(rand_addr());
            wb1_data  = {$urandom, $urandom};
            cycle();
        end

        // Back-to-back issues then an asynchronous reset in the middle of a cycle.
        idle();
        iss_valid = 1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NREG; k++) begin
                if (k != 0 && m_written(k)) m_busy[k] = m_busy[k];
            end
            iss_addr = AW'((i == 2) ? 4 : i + 1);
            wb0_we = 1; wb0_addr = iss_addr; wb0_data = {$urandom, $urandom};
            cycle();
        end
        idle();
        iss_valid = 1; iss_addr = 1;
        set_rd(0, 1);
        set_rd(1, 4);
        dbg_addr = 2;
        @(posedge clk);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("rst busy x1", 64'(rd_busy[0]), 64'd0);
        check("rst busy x4", 64'(rd_busy[1]), 64'd0);
        check("rst pend_cnt", 64'(pend_cnt), 64'd0);
        check("rst x1 data", 64'(rd_data[0 +: XLEN]), 64'd0);
        check("rst dbg x2", 64'(dbg_data), 64'd0);
        check("rst iss_ready", 64'(iss_ready), 64'd1);
        idle();
        for (int a = 0; a < NREG; a++) begin
            dbg_addr = AW'(a);
            #1;
            check($sformatf("rst dbg x%0d", a), 64'(dbg_data), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
